pl_id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage pipelined CPU. Sits directly upstream of the ID/EXE pipeline register and drives its d-side inputs.
- Contains the 32x32 register file, written from WB.
- Contains the control decoder, operand forwarding from EXE/MEM, load-use stall detection, and branch/jump resolution in ID.

---
 rtl/pl_pkg.sv | 71 +++++++
 rtl/pl_regfile.sv | 45 ++++
 rtl/pl_id_stage.sv | 181 ++++++++++++++++++
 tb/tb_pl_id_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_pkg.sv
// Shared encodings for the pipelined CPU decode stage: opcodes, ALU ops,
// forwarding selects and PC-source codes.
package pl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_AND = 4'b0001,
      ALU_XOR = 4'b0010,
      ALU_SLL = 4'b0011,
      ALU_SUB = 4'b0100,
      ALU_OR  = 4'b0101,
      ALU_LUI = 4'b0110,
      ALU_SRL = 4'b0111,
      ALU_SRA = 4'b1111
   } aluc_e;

   typedef enum logic [1:0] {
      FWD_RF   = 2'd0,
      FWD_EALU = 2'd1,
      FWD_MALU = 2'd2,
      FWD_MMO  = 2'd3
   } fwd_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JR     = 2'd2,
      PC_JUMP   = 2'd3
   } pcsrc_e;

   // A load still in EXE has no data yet, so only non-load EXE results forward.
   function automatic fwd_e fwd_select(input logic [4:0] src,
                                       input logic [4:0] ern,
                                       input logic       ewreg,
                                       input logic       em2reg,
                                       input logic [4:0] mrn,
                                       input logic       mwreg,
                                       input logic       mm2reg);
      fwd_e sel;
      sel = FWD_RF;
      if (ewreg && !em2reg && (ern != '0) && (ern == src))
         sel = FWD_EALU;
      else if (mwreg && (mrn != '0) && (mrn == src))
         sel = mm2reg ? FWD_MMO : FWD_MALU;
      return sel;
   endfunction

endpackage

// File: rtl/pl_regfile.sv
// Architectural register file: two combinational read ports with WB
// write-through, one synchronous write port; r0 is hard-wired to zero.
module pl_regfile #(
   parameter int unsigned NREG = 32
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [4:0]  ra,
   input  logic [4:0]  rb,
   output logic [31:0] qa,
   output logic [31:0] qb,
   input  logic        we,
   input  logic [4:0]  wn,
   input  logic [31:0] wd
);

   logic [31:0] regs [NREG];
   logic        wr_active;

   assign wr_active = we && (wn != '0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         regs <= '{default: '0};
      else if (wr_active)
         regs[wn] <= wd;
   end

   always_comb begin
      if (ra == '0)
         qa = '0;
      else if (wr_active && (wn == ra))
         qa = wd;
      else
         qa = regs[ra];

      if (rb == '0)
         qb = '0;
      else if (wr_active && (wn == rb))
         qb = wd;
      else
         qb = regs[rb];
   end

endmodule

// File: rtl/pl_id_stage.sv
// Instruction-decode stage: control decode, operand forwarding, load-use
// stall and branch/jump resolution feeding the ID/EXE register.
module pl_id_stage
   import pl_pkg::*;
#(
   parameter int unsigned NREG      = 32,
   parameter logic [31:0] RESET_PC4 = '0
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] dinst,
   input  logic [31:0] dpc4,
   input  logic [4:0]  wrn,
   input  logic [31:0] wdi,
   input  logic        wwreg,
   input  logic [4:0]  ern,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic [31:0] ealu,
   input  logic [4:0]  mrn,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic [31:0] malu,
   input  logic [31:0] mmo,
   output logic        dwreg,
   output logic        dm2reg,
   output logic        dwmem,
   output logic [3:0]  daluc,
   output logic        daluimm,
   output logic        dshift,
   output logic        djal,
   output logic [31:0] da,
   output logic [31:0] db,
   output logic [31:0] dimm,
   output logic [4:0]  drn,
   output logic [31:0] dpc4_o,
   output logic        wpcir,
   output logic [1:0]  pcsource,
   output logic [31:0] bpc,
   output logic [31:0] jpc
);

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm16;
   logic [25:0] addr26;
   logic [31:0] imm_sext;

   assign op     = dinst[31:26];
   assign rs     = dinst[25:21];
   assign rt     = dinst[20:16];
   assign rd     = dinst[15:11];
   assign sa     = dinst[10:6];
   assign fn     = dinst[5:0];
   assign imm16  = dinst[15:0];
   assign addr26 = dinst[25:0];
   assign imm_sext = {{16{imm16[15]}}, imm16};

   logic [31:0] qa, qb;

   pl_regfile #(.NREG(NREG)) u_regfile (
      .clock  (clock),
      .resetn (resetn),
      .ra     (rs),
      .rb     (rt),
      .qa     (qa),
      .qb     (qb),
      .we     (wwreg),
      .wn     (wrn),
      .wd     (wdi)
   );

   logic  wreg, m2reg, wmem, aluimm, shift, jal;
   logic  uses_rs, uses_rt, dest_rd, dest_rt, imm_zext;
   logic  r_alu, r_shift, br_eq, br_ne, is_jr, is_j;
   aluc_e aluc;

   always_comb begin
      wreg = 1'b0;  m2reg = 1'b0;  wmem = 1'b0;  aluimm = 1'b0;
      shift = 1'b0; jal = 1'b0;    aluc = ALU_ADD;
      uses_rs = 1'b0; uses_rt = 1'b0; dest_rd = 1'b0; dest_rt = 1'b0;
      imm_zext = 1'b0; r_alu = 1'b0; r_shift = 1'b0;
      br_eq = 1'b0; br_ne = 1'b0; is_jr = 1'b0; is_j = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD: begin r_alu = 1'b1;   aluc = ALU_ADD; end
               FN_SUB: begin r_alu = 1'b1;   aluc = ALU_SUB; end
               FN_AND: begin r_alu = 1'b1;   aluc = ALU_AND; end
               FN_OR:  begin r_alu = 1'b1;   aluc = ALU_OR;  end
               FN_XOR: begin r_alu = 1'b1;   aluc = ALU_XOR; end
               FN_SLL: begin r_shift = 1'b1; aluc = ALU_SLL; end
               FN_SRL: begin r_shift = 1'b1; aluc = ALU_SRL; end
               FN_SRA: begin r_shift = 1'b1; aluc = ALU_SRA; end
               FN_JR:  begin is_jr = 1'b1;   uses_rs = 1'b1; end
               default: ;
            endcase
            if (r_alu || r_shift) begin
               wreg = 1'b1; dest_rd = 1'b1; uses_rt = 1'b1;
            end
            if (r_alu)   uses_rs = 1'b1;
            if (r_shift) shift = 1'b1;
         end
         OP_ADDI: begin wreg = 1'b1; dest_rt = 1'b1; aluimm = 1'b1; uses_rs = 1'b1; end
         OP_ANDI: begin wreg = 1'b1; dest_rt = 1'b1; aluimm = 1'b1; uses_rs = 1'b1;
                        aluc = ALU_AND; imm_zext = 1'b1; end
         OP_ORI:  begin wreg = 1'b1; dest_rt = 1'b1; aluimm = 1'b1; uses_rs = 1'b1;
                        aluc = ALU_OR;  imm_zext = 1'b1; end
         OP_XORI: begin wreg = 1'b1; dest_rt = 1'b1; aluimm = 1'b1; uses_rs = 1'b1;
                        aluc = ALU_XOR; imm_zext = 1'b1; end
         OP_LUI:  begin wreg = 1'b1; dest_rt = 1'b1; aluimm = 1'b1;
                        aluc = ALU_LUI; imm_zext = 1'b1; end
         OP_LW:   begin wreg = 1'b1; m2reg = 1'b1; dest_rt = 1'b1; aluimm = 1'b1;
                        uses_rs = 1'b1; end
         OP_SW:   begin wmem = 1'b1; aluimm = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
         OP_BEQ:  begin aluc = ALU_SUB; br_eq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
         OP_BNE:  begin aluc = ALU_SUB; br_ne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
         OP_J:    is_j = 1'b1;
         OP_JAL:  begin is_j = 1'b1; jal = 1'b1; wreg = 1'b1; end
         default: ;
      endcase
   end

   fwd_e        sel_a, sel_b;
   logic [31:0] fa, fb;

   assign sel_a = fwd_select(rs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
   assign sel_b = fwd_select(rt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);

   always_comb begin
      case (sel_a)
         FWD_EALU: fa = ealu;
         FWD_MALU: fa = malu;
         FWD_MMO:  fa = mmo;
         default:  fa = qa;
      endcase
      case (sel_b)
         FWD_EALU: fb = ealu;
         FWD_MALU: fb = malu;
         FWD_MMO:  fb = mmo;
         default:  fb = qb;
      endcase
   end

   logic   stall;
   pcsrc_e pcsel;

   assign stall = ewreg && em2reg && (ern != '0) &&
                  (((ern == rs) && uses_rs) || ((ern == rt) && uses_rt));

   always_comb begin
      pcsel = PC_SEQ;
      if (!stall) begin
         if ((br_eq && (fa == fb)) || (br_ne && (fa != fb)))
            pcsel = PC_BRANCH;
         else if (is_jr)
            pcsel = PC_JR;
         else if (is_j)
            pcsel = PC_JUMP;
      end
   end

   // A stall turns the ID instruction into a bubble without touching the datapath.
   assign dwreg    = wreg & ~stall;
   assign dwmem    = wmem & ~stall;
   assign wpcir    = ~stall;
   assign pcsource = pcsel;
   assign dm2reg   = m2reg;
   assign daluc    = aluc;
   assign daluimm  = aluimm;
   assign dshift   = shift;
   assign djal     = jal;
   assign da       = jal ? dpc4 : fa;
   assign db       = fb;
   assign dpc4_o   = dpc4;
   assign dimm     = shift ? {27'b0, sa} : (imm_zext ? {16'b0, imm16} : imm_sext);
   assign drn      = dest_rd ? rd : (dest_rt ? rt : (jal ? 5'd31 : 5'd0));
   assign bpc      = dpc4 + {imm_sext[29:0], 2'b00};
   assign jpc      = {dpc4[31:28] | RESET_PC4[31:28], addr26, 2'b00};

endmodule

// File: tb/tb_pl_id_stage.sv
// Randomized bench for pl_id_stage against an instruction-table reference model.
module tb_pl_id_stage;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] dinst, dpc4, wdi, ealu, malu, mmo;
   logic [4:0]  wrn, ern, mrn;
   logic        wwreg, ewreg, em2reg, mwreg, mm2reg;
   logic        dwreg, dm2reg, dwmem, daluimm, dshift, djal, wpcir;
   logic [3:0]  daluc;
   logic [31:0] da, db, dimm, dpc4_o, bpc, jpc;
   logic [4:0]  drn;
   logic [1:0]  pcsource;

   pl_id_stage #(.NREG(32), .RESET_PC4(32'h0)) dut (
      .clock(clock), .resetn(resetn), .dinst(dinst), .dpc4(dpc4),
      .wrn(wrn), .wdi(wdi), .wwreg(wwreg),
      .ern(ern), .ewreg(ewreg), .em2reg(em2reg), .ealu(ealu),
      .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .malu(malu), .mmo(mmo),
      .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluc(daluc),
      .daluimm(daluimm), .dshift(dshift), .djal(djal),
      .da(da), .db(db), .dimm(dimm), .drn(drn), .dpc4_o(dpc4_o),
      .wpcir(wpcir), .pcsource(pcsource), .bpc(bpc), .jpc(jpc)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   localparam int D_NONE = 0, D_RD = 1, D_RT = 2, D_31 = 3;
   localparam int I_SEXT = 0, I_ZEXT = 1, I_SA = 2, I_NA = 3;
   localparam int B_NONE = 0, B_EQ = 1, B_NE = 2, B_JR = 3, B_J = 4;

   typedef struct {
      string    name;
      bit [5:0] op;
      bit [5:0] fn;
      bit       wreg, m2reg, wmem, aluimm, shift, jal;
      bit [3:0] aluc;
      bit       ck_aluc;
      int       dest;
      int       immk;
      bit       urs, urt;
      int       br;
   } desc_t;

   desc_t tbl[$];
   logic [31:0] mregs [32];

   task automatic build_table();
      //            name     op     fn     wr m2 wm im sh jl aluc     ck dest    imm     rs rt br
      tbl.push_back('{"add",  6'h00, 6'h20, 1, 0, 0, 0, 0, 0, 4'b0000, 1, D_RD,  I_NA,   1, 1, B_NONE});
      tbl.push_back('{"sub",  6'h00, 6'h22, 1, 0, 0, 0, 0, 0, 4'b0100, 1, D_RD,  I_NA,   1, 1, B_NONE});
      tbl.push_back('{"and",  6'h00, 6'h24, 1, 0, 0, 0, 0, 0, 4'b0001, 1, D_RD,  I_NA,   1, 1, B_NONE});
      tbl.push_back('{"or",   6'h00, 6'h25, 1, 0, 0, 0, 0, 0, 4'b0101, 1, D_RD,  I_NA,   1, 1, B_NONE});
      tbl.push_back('{"xor",  6'h00, 6'h26, 1, 0, 0, 0, 0, 0, 4'b0010, 1, D_RD,  I_NA,   1, 1, B_NONE});
      tbl.push_back('{"sll",  6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 4'b0011, 1, D_RD,  I_SA,   0, 1, B_NONE});
      tbl.push_back('{"srl",  6'h00, 6'h02, 1, 0, 0, 0, 1, 0, 4'b0111, 1, D_RD,  I_SA,   0, 1, B_NONE});
      tbl.push_back('{"sra",  6'h00, 6'h03, 1, 0, 0, 0, 1, 0, 4'b1111, 1, D_RD,  I_SA,   0, 1, B_NONE});
      tbl.push_back('{"jr",   6'h00, 6'h08, 0, 0, 0, 0, 0, 0, 4'b0000, 0, D_NONE, I_NA,  1, 0, B_JR});
      tbl.push_back('{"addi", 6'h08, 6'h00, 1, 0, 0, 1, 0, 0, 4'b0000, 1, D_RT,  I_SEXT, 1, 0, B_NONE});
      tbl.push_back('{"andi", 6'h0C, 6'h00, 1, 0, 0, 1, 0, 0, 4'b0001, 1, D_RT,  I_ZEXT, 1, 0, B_NONE});
      tbl.push_back('{"ori",  6'h0D, 6'h00, 1, 0, 0, 1, 0, 0, 4'b0101, 1, D_RT,  I_ZEXT, 1, 0, B_NONE});
      tbl.push_back('{"xori", 6'h0E, 6'h00, 1, 0, 0, 1, 0, 0, 4'b0010, 1, D_RT,  I_ZEXT, 1, 0, B_NONE});
      tbl.push_back('{"lw",   6'h23, 6'h00, 1, 1, 0, 1, 0, 0, 4'b0000, 1, D_RT,  I_SEXT, 1, 0, B_NONE});
      tbl.push_back('{"sw",   6'h2B, 6'h00, 0, 0, 1, 1, 0, 0, 4'b0000, 1, D_NONE, I_SEXT, 1, 1, B_NONE});
      tbl.push_back('{"beq",  6'h04, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0100, 1, D_NONE, I_SEXT, 1, 1, B_EQ});
      tbl.push_back('{"bne",  6'h05, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0100, 1, D_NONE, I_SEXT, 1, 1, B_NE});
      tbl.push_back('{"lui",  6'h0F, 6'h00, 1, 0, 0, 1, 0, 0, 4'b0110, 1, D_RT,  I_ZEXT, 0, 0, B_NONE});
      tbl.push_back('{"j",    6'h02, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, D_NONE, I_NA,  0, 0, B_J});
      tbl.push_back('{"jal",  6'h03, 6'h00, 1, 0, 0, 0, 0, 1, 4'b0000, 0, D_31,  I_NA,   0, 0, B_J});
      tbl.push_back('{"badop",6'h3F, 6'h00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, D_NONE, I_NA,  0, 0, B_NONE});
      tbl.push_back('{"badfn",6'h00, 6'h3F, 0, 0, 0, 0, 0, 0, 4'b0000, 0, D_NONE, I_NA,  0, 0, B_NONE});
   endtask

   function automatic int find(input string name);
      foreach (tbl[i]) if (tbl[i].name == name) return i;
      return 0;
   endfunction

   function automatic logic [31:0] enc(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa,
                                       input logic [15:0] imm, input logic [25:0] addr);
      desc_t d = tbl[k];
      if (d.br == B_J) return {d.op, addr};
      if (d.op == 6'h00) return {d.op, rs, rt, rd, sa, d.fn};
      return {d.op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rf_read(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
      if (wwreg && wrn == r) return wdi;
      return mregs[r];
   endfunction

   function automatic logic [31:0] fwd(input logic [4:0] r);
      if (ewreg && !em2reg && ern != 5'd0 && ern == r) return ealu;
      if (mwreg && mrn != 5'd0 && mrn == r) return mm2reg ? mmo : malu;
      return rf_read(r);
   endfunction

   task automatic check_all(input string tg, input int k);
      desc_t d = tbl[k];
      logic [4:0]  rs = dinst[25:21];
      logic [4:0]  rt = dinst[20:16];
      logic [4:0]  rd = dinst[15:11];
      logic [31:0] fa = fwd(rs);
      logic [31:0] fb = fwd(rt);
      int signed   off = $signed(dinst[15:0]);
      bit stall;
      logic [1:0]  e_pcs;
      logic [4:0]  e_drn;
      logic [31:0] e_imm;
      stall = ewreg && em2reg && ern != 5'd0 &&
              ((ern == rs && d.urs) || (ern == rt && d.urt));
      e_pcs = 2'd0;
      if (!stall)
         case (d.br)
            B_EQ:    e_pcs = (fa == fb) ? 2'd1 : 2'd0;
            B_NE:    e_pcs = (fa != fb) ? 2'd1 : 2'd0;
            B_JR:    e_pcs = 2'd2;
            B_J:     e_pcs = 2'd3;
            default: e_pcs = 2'd0;
         endcase
      case (d.dest)
         D_RD:    e_drn = rd;
         D_RT:    e_drn = rt;
         D_31:    e_drn = 5'd31;
         default: e_drn = 5'd0;
      endcase
      case (d.immk)
         I_SEXT:  e_imm = 32'(off);
         I_ZEXT:  e_imm = 32'(dinst[15:0]);
         default: e_imm = 32'(dinst[10:6]);
      endcase
      check_val({tg, ".dwreg"},   32'(dwreg),   32'(d.wreg && !stall));
      check_val({tg, ".dm2reg"},  32'(dm2reg),  32'(d.m2reg));
      check_val({tg, ".dwmem"},   32'(dwmem),   32'(d.wmem && !stall));
      check_val({tg, ".daluimm"}, 32'(daluimm), 32'(d.aluimm));
      check_val({tg, ".dshift"},  32'(dshift),  32'(d.shift));
      check_val({tg, ".djal"},    32'(djal),    32'(d.jal));
      check_val({tg, ".drn"},     32'(drn),     32'(e_drn));
      check_val({tg, ".da"},      da,           d.jal ? dpc4 : fa);
      check_val({tg, ".db"},      db,           fb);
      check_val({tg, ".wpcir"},   32'(wpcir),   32'(!stall));
      check_val({tg, ".pcsource"},32'(pcsource),32'(e_pcs));
      check_val({tg, ".bpc"},     bpc,          dpc4 + 32'(off * 4));
      check_val({tg, ".jpc"},     jpc,          (dpc4 & 32'hF000_0000) | 32'(dinst[25:0] * 4));
      check_val({tg, ".dpc4_o"},  dpc4_o,       dpc4);
      if (d.ck_aluc) check_val({tg, ".daluc"}, 32'(daluc), 32'(d.aluc));
      if (d.immk != I_NA) check_val({tg, ".dimm"}, dimm, e_imm);
   endtask

   task automatic tick();
      @(posedge clock);
      if (!resetn) foreach (mregs[i]) mregs[i] = 32'h0;
      else if (wwreg && wrn != 5'd0) mregs[wrn] = wdi;
      #1;
   endtask

   task automatic idle();
      dinst = '0; dpc4 = '0; wrn = '0; wdi = '0; wwreg = 1'b0;
      ern = '0; ewreg = 1'b0; em2reg = 1'b0; ealu = '0;
      mrn = '0; mwreg = 1'b0; mm2reg = 1'b0; malu = '0; mmo = '0;
   endtask

   int k_add, k_beq, k_jal;

   initial begin
      build_table();
      k_add = find("add"); k_beq = find("beq"); k_jal = find("jal");
      foreach (mregs[i]) mregs[i] = 32'h0;
      idle();
      resetn = 1'b0;
      #3;
      check_val("rst.wpcir", 32'(wpcir), 32'd1);
      check_val("rst.pcsource", 32'(pcsource), 32'd0);
      check_val("rst.dwreg", 32'(dwreg), 32'd1);
      check_val("rst.drn", 32'(drn), 32'd0);
      check_val("rst.da", da, 32'h0);
      tick(); tick();
      resetn = 1'b1;

      // WB write then read back
      wwreg = 1'b1; wrn = 5'd5; wdi = 32'h1234;
      tick();
      wwreg = 1'b0; dinst = enc(k_add, 5'd5, 5'd0, 5'd6, 5'd0, 16'h0, 26'h0);
      #2;
      check_val("wb.da", da, 32'h1234);
      check_val("wb.wpcir", 32'(wpcir), 32'd1);
      check_val("wb.drn", 32'(drn), 32'd6);
      check_val("wb.daluc", 32'(daluc), 32'd0);
      check_all("wb", k_add);
      tick();

      // same-cycle write-through
      wwreg = 1'b1; wrn = 5'd7; wdi = 32'hAA;
      dinst = enc(k_add, 5'd7, 5'd0, 5'd1, 5'd0, 16'h0, 26'h0);
      #2;
      check_val("wt.da", da, 32'hAA);
      check_all("wt", k_add);
      tick();
      idle();

      // EXE beats MEM
      ern = 5'd3; ewreg = 1'b1; ealu = 32'h10; mrn = 5'd3; mwreg = 1'b1; malu = 32'h20;
      dinst = enc(k_add, 5'd3, 5'd0, 5'd1, 5'd0, 16'h0, 26'h0);
      #2;
      check_val("prio.da", da, 32'h10);
      check_all("prio", k_add);
      tick();
      idle();

      // load-use stall then MEM load forward
      ern = 5'd4; ewreg = 1'b1; em2reg = 1'b1;
      dinst = enc(k_add, 5'd4, 5'd2, 5'd1, 5'd0, 16'h0, 26'h0);
      #2;
      check_val("lu.wpcir", 32'(wpcir), 32'd0);
      check_val("lu.dwreg", 32'(dwreg), 32'd0);
      check_val("lu.dwmem", 32'(dwmem), 32'd0);
      check_all("lu", k_add);
      tick();
      ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
      mrn = 5'd4; mwreg = 1'b1; mm2reg = 1'b1; mmo = 32'h55;
      #2;
      check_val("lu2.da", da, 32'h55);
      check_val("lu2.wpcir", 32'(wpcir), 32'd1);
      check_all("lu2", k_add);
      tick();
      idle();

      // beq taken with both operands forwarded
      ern = 5'd1; ewreg = 1'b1; ealu = 32'd5; mrn = 5'd2; mwreg = 1'b1; malu = 32'd5;
      dpc4 = 32'h100; dinst = enc(k_beq, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'h0);
      #2;
      check_val("beq.pcsource", 32'(pcsource), 32'd1);
      check_val("beq.bpc", bpc, 32'hF8);
      check_all("beq", k_beq);
      tick();
      idle();

      // jal
      dpc4 = 32'h1000_0004; dinst = enc(k_jal, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40);
      #2;
      check_val("jal.pcsource", 32'(pcsource), 32'd3);
      check_val("jal.jpc", jpc, 32'h1000_0100);
      check_val("jal.drn", 32'(drn), 32'd31);
      check_val("jal.djal", 32'(djal), 32'd1);
      check_all("jal", k_jal);
      tick();
      idle();

      // r0 write ignored
      wwreg = 1'b1; wrn = 5'd0; wdi = 32'hFFFF;
      tick();
      wwreg = 1'b0; dinst = enc(k_add, 5'd0, 5'd0, 5'd1, 5'd0, 16'h0, 26'h0);
      #2;
      check_val("r0.da", da, 32'h0);
      tick();

      for (int n = 0; n < 400; n++) begin
         int k;
         logic [4:0] rs, rt;
         k  = int'($urandom_range(0, tbl.size() - 1));
         rs = 5'($urandom_range(0, 7));
         rt = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 7));
         dinst  = enc(k, rs, rt, 5'($urandom_range(0, 7)), 5'($urandom),
                      16'($urandom), 26'($urandom));
         if (tbl[k].name == "badop") dinst = {6'h3F, 26'($urandom)};
         dpc4   = $urandom;
         wwreg  = 1'($urandom); wrn = 5'($urandom_range(0, 7)); wdi = $urandom;
         ewreg  = 1'($urandom); em2reg = 1'($urandom); ern = 5'($urandom_range(0, 7));
         ealu   = $urandom;
         mwreg  = 1'($urandom); mm2reg = 1'($urandom); mrn = 5'($urandom_range(0, 7));
         malu   = $urandom; mmo = $urandom;
         #2;
         check_all({"rnd.", tbl[k].name}, k);
         tick();
      end

      // reset during a write: the write is lost
      idle();
      wwreg = 1'b1; wrn = 5'd5; wdi = 32'hDEAD;
      #2;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      idle();
      dinst = enc(k_add, 5'd5, 5'd7, 5'd1, 5'd0, 16'h0, 26'h0);
      #2;
      check_val("rstwr.da", da, 32'h0);
      check_val("rstwr.db", db, 32'h0);
      check_all("rstwr", k_add);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
